multiplicador_seq: RTL

- Self-contained sequential shift-and-add multiplier: datapath (A/B/Q registers, adder, down-counter) plus integrated control FSM with start/done handshake.
- Adds a signed two's-complement mode, a synchronous abort and a held, registered result.
- Instantiated as a shared arithmetic unit by higher-level controllers; one multiplication at a time.

---
 rtl/multiplicador_seq_if.sv | 24 ++
 rtl/multiplicador_seq.sv | 133 +++++++++++++
 2 files changed

// File: rtl/multiplicador_seq_if.sv
// Operand/result bundle between a controller and the shared sequential multiplier.
// The controller drives master; the multiplier consumes through slave.
interface multiplicador_seq_if #(
  parameter int WIDTH = 8
);
  logic                 start;
  logic                 signed_mode;
  logic                 abort;
  logic [WIDTH-1:0]     a_in;
  logic [WIDTH-1:0]     b_in;
  logic                 busy;
  logic                 done;
  logic [2*WIDTH-1:0]   p_out;

  modport master (
    output start, signed_mode, abort, a_in, b_in,
    input  busy, done, p_out
  );

  modport slave (
    input  start, signed_mode, abort, a_in, b_in,
    output busy, done, p_out
  );
endinterface

// File: rtl/multiplicador_seq.sv
// Shift-and-add multiplier, signed/unsigned, WIDTH+2 cycles start to done; one op at a time.
// start is only taken in IDLE (no queuing); abort cancels CALC/FIX and keeps the previous product.
module multiplicador_seq #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  multiplicador_seq_if.slave bus
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t             state;
  state_t             state_nxt;

  logic [WIDTH-1:0]   a_r;
  logic [WIDTH-1:0]   b_r;
  logic [WIDTH-1:0]   q_r;
  logic               carry_r;
  logic [CW-1:0]      cnt_r;
  logic               neg_r;
  logic [2*WIDTH-1:0] p_r;

  logic               load;
  logic               step;
  logic               fix;

  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [WIDTH-1:0]   addend;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] prod_fixed;

  // Magnitude in WIDTH unsigned bits; the most negative value maps onto itself, which is correct unsigned.
  assign a_mag = (bus.signed_mode && bus.a_in[WIDTH-1]) ? (~bus.a_in + WIDTH'(1)) : bus.a_in;
  assign b_mag = (bus.signed_mode && bus.b_in[WIDTH-1]) ? (~bus.b_in + WIDTH'(1)) : bus.b_in;

  assign addend     = q_r[0] ? b_r : '0;
  assign sum        = {carry_r, a_r} + {1'b0, addend};
  assign prod       = {a_r, q_r};
  assign prod_fixed = neg_r ? (~prod + (2*WIDTH)'(1)) : prod;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    step      = 1'b0;
    fix       = 1'b0;
    case (state)
      IDLE: begin
        // start beats a simultaneous abort here: abort only acts on a running op.
        if (bus.start) begin
          load      = 1'b1;
          state_nxt = CALC;
        end
      end
      CALC: begin
        if (bus.abort) begin
          state_nxt = IDLE;
        end else begin
          step = 1'b1;
          if (cnt_r == '0) begin
            state_nxt = FIX;
          end
        end
      end
      FIX: begin
        if (bus.abort) begin
          state_nxt = IDLE;
        end else begin
          fix       = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_r     <= '0;
      b_r     <= '0;
      q_r     <= '0;
      carry_r <= 1'b0;
      cnt_r   <= '0;
      neg_r   <= 1'b0;
    end else if (load) begin
      a_r     <= '0;
      b_r     <= a_mag;
      q_r     <= b_mag;
      carry_r <= 1'b0;
      cnt_r   <= CW'(WIDTH - 1);
      neg_r   <= bus.signed_mode & (bus.a_in[WIDTH-1] ^ bus.b_in[WIDTH-1]);
    end else if (step) begin
      // {carry,A,Q} >> 1 after the conditional add; a zero enters at the top.
      {carry_r, a_r, q_r} <= {1'b0, sum, q_r[WIDTH-1:1]};
      cnt_r               <= cnt_r - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      p_r <= '0;
    end else if (fix) begin
      p_r <= prod_fixed;
    end
  end

  assign bus.busy  = (state == CALC) || (state == FIX);
  assign bus.done  = (state == DONE);
  assign bus.p_out = p_r;

endmodule
